alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised two-stage pipelined ALU; successor to the single-cycle execute ALU.
//  Covers ADD/ADC/SUB/SBC/AND/ORR/EOR/BIC/MOV_LAS with a full operand-2 barrel shifter.
//  Holds NZCV flags internally and uses valid/ready handshakes on both sides.
//  Sits between decode (upstream) and register writeback (downstream); supports flush on branch.
// PARAMETERS
//  WIDTH    32  datapath width; legal range 12..64
//  SHAMT_W  8   width of the register shift amount (rs)
// PORTS
//  clk          in   1          clock, rising edge
//  rst          in   1          reset; synchronous, active-high
//  flush        in   1          drops all in-flight ops; flags are kept
//  in_valid     in   1          op presented
//  in_ready     out  1          op accepted when in_valid && in_ready
//  op           in   5          00 ADD, 01 ADC, 02 SUB, 03 SBC, 04 AND, 05 ORR, 06 EOR, 07 BIC, 08 MOV_LAS
//  rn           in   WIDTH      operand 1
//  rm           in   WIDTH      operand to shift
//  rs           in   SHAMT_W    register shift amount
//  imm_shift    in   5          immediate shift amount
//  imm_operand  in   12         immediate operand 2, zero-extended
//  imm          in   1          select immediate forms
//  set_flags    in   1          S bit
//  stype        in   2          shift type: 0 LSL, 1 LSR, 2 ASR, 3 ROR
//  out_valid    out  1          result present
//  out_ready    in   1          result consumed when out_valid && out_ready
//  rd           out  WIDTH      result
//  out_n        out  1          output N flag, registered with rd
//  out_z        out  1          output Z flag, registered with rd
//  out_c        out  1          output C flag, registered with rd
//  out_v        out  1          output V flag, registered with rd
//  flags        out  4          committed {N,Z,C,V} register
// BEHAVIOUR
//  Reset:
//   - s1_valid=0, out_valid=0, rd=0, out flags=0, flags=4'b0000.
//   - in_ready=1 on the first cycle after reset.
//  Stage 1 (shift):
//   - shift amount sh = imm ? imm_shift : rs. Shift rm by sh using stype, producing shifted value and shifter carry sc.
//   - sh==0: value=rm, sc=flags.C.
//   - LSL: sh<W gives carry rm[W-sh]; sh==W gives 0, carry rm[0]; sh>W gives 0, carry 0.
//   - LSR: sh<W gives carry rm[sh-1]; sh==W gives 0, carry rm[W-1]; sh>W gives 0, carry 0.
//   - ASR: sh>=W gives all sign bits, carry = sign.
//   - ROR: rotate by sh mod W; carry = result[W-1].
//   - op2 = (imm && op!=MOV_LAS) ? zext(imm_operand) : shifted.
//   - The stage registers op2, sc, rn, op and set_flags.
//  Stage 2 (arith), evaluated from the stage-1 register and the committed flags:
//   - ADD rn+op2; ADC rn+op2+C.
//   - SUB rn+~op2+1; SBC rn+~op2+C.
//   - AND rn&op2; ORR rn|op2; EOR rn^op2; BIC rn&~op2; MOV_LAS rd=op2.
//   - Arithmetic ops: C = carry out of bit W-1 (SUB/SBC: C=1 means no borrow); V = signed overflow.
//   - Logical ops and MOV_LAS: C = sc; V unchanged.
//   - N = rd[W-1]; Z = (rd==0).
//   - Undefined op: rd=0, flags unchanged, token still delivered in order.
//  Handshake and pipeline:
//   - adv2 = s1_valid && (!out_valid || out_ready); adv1 = in_valid && in_ready.
//   - in_ready = !s1_valid || !out_valid || out_ready. It is combinational, with no dependency on in_valid.
//   - Latency: an op accepted in cycle t drives out_valid in t+2 if not stalled. Throughput is 1 op/cycle.
//   - rd and out flags hold stable while out_valid && !out_ready.
//   - out_valid clears on a pop with no adv2 in the same cycle.
//  Flag commit:
//   - On adv2 with set_flags=1, flags load the new NZCV in the same edge as rd.
//   - A back-to-back ADC/SBC therefore sees the previous op's carry (no hazard).
//   - With set_flags=0, flags hold, but out_n..out_v still show the computed values.
//  Flush:
//   - Next edge clears s1_valid and out_valid; flags are not rolled back.
//   - Any in-cycle accept or commit is cancelled.
//   - rst has priority over flush.
// TESTING
//  1. rst, then ADD rn=5, rm=3, lsl#0, S=1 -> 2 cycles later rd=8, flags=0000.
//  2. SUBS 3-5, then ADCS 0+0 back-to-back
//     -> rd=FFFFFFFE with N=1, C=0; next rd=0, Z=1, C=0.
//  3. MOV_LAS rm=80000001, ASR by 1, then 33, then 0, each S=1
//     -> rd=C0000000 C=1; FFFFFFFF C=1; 80000001 C holds.
//  4. out_ready=0 for 3 cycles with 3 ops in flight
//     -> in_ready=0 after 2 accepts, rd stable; release gives 3 in-order results, none lost.
//  5. ADDS 7FFFFFFF+1 -> rd=80000000, N=1, V=1, C=0.
//  6. flush while two ops are in flight -> out_valid=0 next cycle; flags equal the pre-flush value.
//     Repeat 1, 3 and 5 with WIDTH=16.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with an operand-2 barrel shifter.
// Stage 1 shifts rm and selects operand 2. Stage 2 does the arithmetic or
// logic op and commits NZCV. Both sides use valid/ready, and flush drops
// everything in flight while keeping the committed flags.
module alu_pipe #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         op,
    input  logic [WIDTH-1:0]   rn,
    input  logic [WIDTH-1:0]   rm,
    input  logic [SHAMT_W-1:0] rs,
    input  logic [4:0]         imm_shift,
    input  logic [11:0]        imm_operand,
    input  logic               imm,
    input  logic               set_flags,
    input  logic [1:0]         stype,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   rd,
    output logic               out_n,
    output logic               out_z,
    output logic               out_c,
    output logic               out_v,
    output logic [3:0]         flags
);

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_ADC = 5'd1;
    localparam logic [4:0] OP_SUB = 5'd2;
    localparam logic [4:0] OP_SBC = 5'd3;
    localparam logic [4:0] OP_AND = 5'd4;
    localparam logic [4:0] OP_ORR = 5'd5;
    localparam logic [4:0] OP_EOR = 5'd6;
    localparam logic [4:0] OP_BIC = 5'd7;
    localparam logic [4:0] OP_MOV = 5'd8;

    // The shift amount must hold both the 5-bit immediate and the rs field.
    localparam int SH_W = (SHAMT_W > 5) ? SHAMT_W : 5;

    // stage-1 state
    logic             s1_valid;
    logic [WIDTH-1:0] s1_op2;
    logic [WIDTH-1:0] s1_rn;
    logic             s1_sc;
    logic             s1_sc_keep;
    logic [4:0]       s1_op;
    logic             s1_set_flags;

    // shifter
    logic [SH_W-1:0]   sh;
    logic [31:0]       rot_amt;
    logic [WIDTH:0]    lsl_ext;
    logic [WIDTH:0]    lsr_ext;
    logic signed [WIDTH:0] asr_ext;
    logic [WIDTH-1:0]  ror_val;
    logic [WIDTH-1:0]  shifted;
    logic [WIDTH-1:0]  op2;
    logic              sc;
    logic              sc_keep;

    // stage-2 evaluation
    logic [WIDTH-1:0]  s2_b;
    logic              s2_cin;
    logic [WIDTH:0]    s2_sum;
    logic [WIDTH-1:0]  s2_rd;
    logic              s2_cflag;
    logic              s2_defined;
    logic              s2_n;
    logic              s2_z;
    logic              s2_c;
    logic              s2_v;

    logic adv1;
    logic adv2;

    assign in_ready = !s1_valid || !out_valid || out_ready;
    assign adv1     = in_valid && in_ready;
    assign adv2     = s1_valid && (!out_valid || out_ready);

    // Barrel shifter and operand-2 select. An extra bit on each shift
    // carries the last bit shifted out, which is the shifter carry for
    // every amount from 1 up to and past WIDTH. A zero amount defers the
    // carry to stage 2, where the committed C is known to be current even
    // for back-to-back ops.
    always_comb begin
        sh      = imm ? SH_W'(imm_shift) : SH_W'(rs);
        lsl_ext = {1'b0, rm} << sh;
        lsr_ext = {rm, 1'b0} >> sh;
        asr_ext = $signed({rm, 1'b0}) >>> sh;
        rot_amt = 32'(sh) % 32'(WIDTH);
        ror_val = (rm >> rot_amt) | (rm << (32'(WIDTH) - rot_amt));
        shifted = rm;
        sc      = 1'b0;
        sc_keep = 1'b0;
        if (sh == '0) begin
            sc_keep = 1'b1;
        end else begin
            case (stype)
                2'd0:    {sc, shifted} = lsl_ext;
                2'd1:    {shifted, sc} = lsr_ext;
                2'd2:    {shifted, sc} = asr_ext;
                default: begin
                    shifted = ror_val;
                    sc      = ror_val[WIDTH-1];
                end
            endcase
        end
        op2 = (imm && (op != OP_MOV)) ? WIDTH'(imm_operand) : shifted;
    end

    // Stage-2 ALU evaluated from the stage-1 register and committed flags.
    // Undefined ops produce zero and echo the committed flags.
    always_comb begin
        s2_b       = s1_op2;
        s2_cin     = 1'b0;
        s2_sum     = '0;
        s2_rd      = '0;
        s2_defined = 1'b1;
        s2_cflag   = s1_sc_keep ? flags[1] : s1_sc;
        s2_c       = flags[1];
        s2_v       = flags[0];
        case (s1_op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                s2_b   = ((s1_op == OP_SUB) || (s1_op == OP_SBC)) ? ~s1_op2 : s1_op2;
                s2_cin = (s1_op == OP_ADD) ? 1'b0 :
                         (s1_op == OP_SUB) ? 1'b1 : flags[1];
                s2_sum = {1'b0, s1_rn} + {1'b0, s2_b} + (WIDTH+1)'(s2_cin);
                s2_rd  = s2_sum[WIDTH-1:0];
                s2_c   = s2_sum[WIDTH];
                s2_v   = (s1_rn[WIDTH-1] == s2_b[WIDTH-1]) &&
                         (s2_rd[WIDTH-1] != s1_rn[WIDTH-1]);
            end
            OP_AND: begin
                s2_rd = s1_rn & s1_op2;
                s2_c  = s2_cflag;
            end
            OP_ORR: begin
                s2_rd = s1_rn | s1_op2;
                s2_c  = s2_cflag;
            end
            OP_EOR: begin
                s2_rd = s1_rn ^ s1_op2;
                s2_c  = s2_cflag;
            end
            OP_BIC: begin
                s2_rd = s1_rn & ~s1_op2;
                s2_c  = s2_cflag;
            end
            OP_MOV: begin
                s2_rd = s1_op2;
                s2_c  = s2_cflag;
            end
            default: s2_defined = 1'b0;
        endcase
        s2_n = s2_defined ? s2_rd[WIDTH-1] : flags[3];
        s2_z = s2_defined ? (s2_rd == '0)  : flags[2];
    end

    // Stage-1 register: capture the shifted operand on accept, empty on advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_op2       <= '0;
            s1_rn        <= '0;
            s1_sc        <= 1'b0;
            s1_sc_keep   <= 1'b0;
            s1_op        <= '0;
            s1_set_flags <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (adv1) begin
            s1_valid     <= 1'b1;
            s1_op2       <= op2;
            s1_rn        <= rn;
            s1_sc        <= sc;
            s1_sc_keep   <= sc_keep;
            s1_op        <= op;
            s1_set_flags <= set_flags;
        end else if (adv2) begin
            s1_valid <= 1'b0;
        end
    end

    // Output register and flag commit; both load on the same advance edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            rd        <= '0;
            out_n     <= 1'b0;
            out_z     <= 1'b0;
            out_c     <= 1'b0;
            out_v     <= 1'b0;
            flags     <= 4'b0000;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (adv2) begin
            out_valid <= 1'b1;
            rd        <= s2_rd;
            out_n     <= s2_n;
            out_z     <= s2_z;
            out_c     <= s2_c;
            out_v     <= s2_v;
            if (s1_set_flags) begin
                flags <= {s2_n, s2_z, s2_c, s2_v};
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe at WIDTH=32 and WIDTH=16. Each width gets directed
// cases with literal expectations, then random traffic checked every cycle
// against an in-order queue model of the pipe.
module tb_alu_pipe;

    typedef struct {
        logic [4:0]  op;
        logic [63:0] rn;
        logic [63:0] rm;
        logic [7:0]  rs;
        logic [4:0]  ish;
        logic [11:0] iop;
        logic        imm;
        logic        sf;
        logic [1:0]  st;
    } op_t;

    typedef struct {
        logic [63:0] rd;
        logic [3:0]  nzcv;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit fin [2];

    task automatic check(input int w, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL w%0d %s: got %h expected %h at %0t", w, nm, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_w
        localparam int W = (gi == 0) ? 32 : 16;
        localparam logic [W-1:0] ONES = '1;
        localparam logic [W-1:0] MSB  = {1'b1, {(W-1){1'b0}}};
        localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
        localparam logic [W-1:0] MSB1 = {1'b1, {(W-2){1'b0}}, 1'b1};
        localparam logic [W-1:0] TOP2 = {2'b11, {(W-2){1'b0}}};
        localparam logic [W-1:0] M2   = {{(W-1){1'b1}}, 1'b0};

        logic         rst, flush, in_valid, in_ready, imm, set_flags;
        logic         out_valid, out_ready, out_n, out_z, out_c, out_v;
        logic [4:0]   op, imm_shift;
        logic [W-1:0] rn, rm, rd;
        logic [7:0]   rs;
        logic [11:0]  imm_operand;
        logic [1:0]   stype;
        logic [3:0]   flags;

        alu_pipe #(.WIDTH(W), .SHAMT_W(8)) dut (
            .clk(clk), .rst(rst), .flush(flush),
            .in_valid(in_valid), .in_ready(in_ready),
            .op(op), .rn(rn), .rm(rm), .rs(rs), .imm_shift(imm_shift),
            .imm_operand(imm_operand), .imm(imm), .set_flags(set_flags), .stype(stype),
            .out_valid(out_valid), .out_ready(out_ready), .rd(rd),
            .out_n(out_n), .out_z(out_z), .out_c(out_c), .out_v(out_v),
            .flags(flags)
        );

        // Reference: result of one op given the committed flags at its turn.
        function automatic void model(input op_t x, input logic [3:0] f,
                                      output logic [W-1:0] r, output logic [3:0] nzcv);
            int sh, k;
            logic [W-1:0] a, m, sv, op2, b;
            logic sc, c, v, cin;
            longint u, s, lim;
            a  = W'(x.rn);
            m  = W'(x.rm);
            sh = x.imm ? int'(x.ish) : int'(x.rs);
            sv = m;
            sc = f[1];
            if (sh != 0) begin
                case (x.st)
                    2'd0: if (sh < W) begin sv = m << sh; sc = m[W-sh]; end
                          else begin sv = '0; sc = (sh == W) ? m[0] : 1'b0; end
                    2'd1: if (sh < W) begin sv = m >> sh; sc = m[sh-1]; end
                          else begin sv = '0; sc = (sh == W) ? m[W-1] : 1'b0; end
                    2'd2: if (sh < W) begin sv = W'($signed(m) >>> sh); sc = m[sh-1]; end
                          else begin sv = {W{m[W-1]}}; sc = m[W-1]; end
                    default: begin
                        k  = sh % W;
                        sv = (k == 0) ? m : ((m >> k) | (m << (W - k)));
                        sc = sv[W-1];
                    end
                endcase
            end
            op2  = (x.imm && x.op != 5'd8) ? W'(x.iop) : sv;
            r    = '0;
            nzcv = f;
            if (x.op <= 5'd3) begin
                b   = (x.op >= 5'd2) ? ~op2 : op2;
                cin = (x.op == 5'd0) ? 1'b0 : (x.op == 5'd2) ? 1'b1 : f[1];
                u   = longint'(a) + longint'(b) + longint'(cin);
                s   = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
                lim = longint'(1) <<< (W - 1);
                r   = W'(u);
                c   = (u >= (longint'(1) <<< W));
                v   = (s >= lim) || (s < -lim);
                nzcv = {r[W-1], r == '0, c, v};
            end else if (x.op <= 5'd8) begin
                case (x.op)
                    5'd4:    r = a & op2;
                    5'd5:    r = a | op2;
                    5'd6:    r = a ^ op2;
                    5'd7:    r = a & ~op2;
                    default: r = op2;
                endcase
                nzcv = {r[W-1], r == '0, sc, f[0]};
            end
        endfunction

        op_t          pend[$];
        res_t         done[$];
        logic [3:0]   cflags;
        op_t          cur, nxt;
        res_t         rr;
        logic [W-1:0] rd_m;
        logic [3:0]   nz_m;
        logic         exp_rdy;

        // Compare process: check outputs against the model, then step the
        // model for the coming edge with the inputs now on the bus.
        always @(negedge clk) begin
            if (rst) begin
                pend.delete();
                done.delete();
                cflags = 4'b0000;
            end else begin
                exp_rdy = (pend.size() == 0) || (done.size() == 0) || out_ready;
                check(W, "in_ready", 64'(in_ready), 64'(exp_rdy));
                check(W, "out_valid", 64'(out_valid), 64'(done.size() > 0));
                if (done.size() > 0) begin
                    check(W, "rd", 64'(rd), done[0].rd);
                    check(W, "out_nzcv", 64'({out_n, out_z, out_c, out_v}), 64'(done[0].nzcv));
                end
                check(W, "flags", 64'(flags), 64'(cflags));
                if (flush) begin
                    pend.delete();
                    done.delete();
                end else begin
                    cur = '{op, 64'(rn), 64'(rm), rs, imm_shift, imm_operand, imm, set_flags, stype};
                    if (done.size() > 0 && out_ready) void'(done.pop_front());
                    if (pend.size() > 0 && done.size() == 0) begin
                        nxt = pend.pop_front();
                        model(nxt, cflags, rd_m, nz_m);
                        rr.rd   = 64'(rd_m);
                        rr.nzcv = nz_m;
                        done.push_back(rr);
                        if (nxt.sf) cflags = nz_m;
                    end
                    if (in_valid && exp_rdy) pend.push_back(cur);
                end
            end
        end

        task automatic drive(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [7:0] r, input logic [4:0] ish, input logic [11:0] iop,
                             input logic im, input logic sf, input logic [1:0] st);
            op = o; rn = a; rm = b; rs = r; imm_shift = ish; imm_operand = iop;
            imm = im; set_flags = sf; stype = st; in_valid = 1'b1;
        endtask

        task automatic send(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [7:0] r, input logic [4:0] ish, input logic [11:0] iop,
                            input logic im, input logic sf, input logic [1:0] st);
            int k;
            k = 0;
            drive(o, a, b, r, ish, iop, im, sf, st);
            @(negedge clk);
            while (!in_ready && k < 50) begin
                @(negedge clk);
                k++;
            end
            if (!in_ready) begin
                n_cmp++;
                n_bad++;
                $display("FAIL w%0d send: in_ready stuck at 0 for 50 cycles", W);
            end
            @(posedge clk);
            #1 in_valid = 1'b0;
        endtask

        task automatic expect_out(input string nm, input logic [W-1:0] erd,
                                  input logic [3:0] enz, input logic [3:0] ef);
            int k;
            k = 0;
            @(negedge clk);
            while (!out_valid && k < 50) begin
                @(negedge clk);
                k++;
            end
            check(W, {nm, "_valid"}, 64'(out_valid), 64'(1));
            check(W, {nm, "_rd"}, 64'(rd), 64'(erd));
            check(W, {nm, "_nzcv"}, 64'({out_n, out_z, out_c, out_v}), 64'(enz));
            check(W, {nm, "_flags"}, 64'(flags), 64'(ef));
            @(posedge clk);
            #1;
        endtask

        function automatic logic [W-1:0] pick();
            case ($urandom_range(0, 5))
                0:       return '0;
                1:       return ONES;
                2:       return MSB;
                3:       return SMAX;
                default: return W'({$urandom, $urandom});
            endcase
        endfunction

        initial begin
            rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
            op = '0; rn = '0; rm = '0; rs = '0; imm_shift = '0; imm_operand = '0;
            imm = 1'b0; set_flags = 1'b0; stype = '0;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            check(W, "rst_rd", 64'(rd), 64'(0));
            check(W, "rst_flags", 64'(flags), 64'(0));
            check(W, "rst_out_valid", 64'(out_valid), 64'(0));
            check(W, "rst_out_nzcv", 64'({out_n, out_z, out_c, out_v}), 64'(0));
            check(W, "rst_in_ready", 64'(in_ready), 64'(1));

            // ADDS 5 + 3
            send(5'd0, W'(5), W'(3), 8'd0, 5'd0, 12'd0, 1'b0, 1'b1, 2'd0);
            expect_out("adds", W'(8), 4'b0000, 4'b0000);

            // SUBS 3-5 then ADCS 0+0 back-to-back
            send(5'd2, W'(3), W'(5), 8'd0, 5'd0, 12'd0, 1'b0, 1'b1, 2'd0);
            send(5'd1, W'(0), W'(0), 8'd0, 5'd0, 12'd0, 1'b0, 1'b1, 2'd0);
            expect_out("subs", M2, 4'b1000, 4'b1000);
            expect_out("adcs", W'(0), 4'b0100, 4'b0100);

            // MOV_LAS ASR by 1, 33, 0
            send(5'd8, W'(0), MSB1, 8'd0, 5'd1, 12'd0, 1'b1, 1'b1, 2'd2);
            expect_out("asr1", TOP2, 4'b1010, 4'b1010);
            send(5'd8, W'(0), MSB1, 8'd33, 5'd0, 12'd0, 1'b0, 1'b1, 2'd2);
            expect_out("asr33", ONES, 4'b1010, 4'b1010);
            send(5'd8, W'(0), MSB1, 8'd0, 5'd0, 12'd0, 1'b0, 1'b1, 2'd2);
            expect_out("asr0", MSB1, 4'b1010, 4'b1010);

            // ADDS signed overflow
            send(5'd0, SMAX, W'(1), 8'd0, 5'd0, 12'd0, 1'b0, 1'b1, 2'd0);
            expect_out("ovf", MSB, 4'b1001, 4'b1001);

            // Back-pressure with three ops offered
            out_ready = 1'b0;
            drive(5'd0, W'(1), W'(2), 8'd0, 5'd0, 12'd0, 1'b0, 1'b0, 2'd0);
            @(posedge clk); #1;
            drive(5'd5, W'(8'hF0), W'(0), 8'd0, 5'd0, 12'h00F, 1'b1, 1'b0, 2'd0);
            @(posedge clk); #1;
            drive(5'd2, W'(10), W'(4), 8'd0, 5'd0, 12'd0, 1'b0, 1'b0, 2'd0);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check(W, "stall_in_ready", 64'(in_ready), 64'(0));
                check(W, "stall_rd", 64'(rd), 64'(3));
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
            expect_out("stall_a", W'(3), 4'b0000, 4'b1001);
            in_valid = 1'b0;
            expect_out("stall_b", W'(8'hFF), 4'b0001, 4'b1001);
            expect_out("stall_c", W'(6), 4'b0010, 4'b1001);

            // Flush with two ops in flight
            out_ready = 1'b0;
            send(5'd0, W'(0), W'(0), 8'd0, 5'd0, 12'd0, 1'b0, 1'b1, 2'd0);
            send(5'd0, SMAX, W'(1), 8'd0, 5'd0, 12'd0, 1'b0, 1'b1, 2'd0);
            flush = 1'b1;
            @(negedge clk);
            check(W, "preflush_flags", 64'(flags), 64'(4'b0100));
            @(posedge clk);
            #1 flush = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            check(W, "flush_out_valid", 64'(out_valid), 64'(0));
            check(W, "flush_flags", 64'(flags), 64'(4'b0100));
            @(posedge clk);
            #1;

            // Random traffic
            for (int i = 0; i < 3000; i++) begin
                rst         = ($urandom_range(0, 299) == 0);
                flush       = ($urandom_range(0, 39) == 0);
                in_valid    = ($urandom_range(0, 9) < 7);
                out_ready   = ($urandom_range(0, 9) < 7);
                op          = 5'($urandom_range(0, 10));
                rn          = pick();
                rm          = pick();
                rs          = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 2 * W + 2));
                imm_shift   = 5'($urandom);
                imm_operand = 12'($urandom);
                imm         = 1'($urandom_range(0, 1));
                set_flags   = ($urandom_range(0, 3) != 0);
                stype       = 2'($urandom);
                @(posedge clk);
                #1;
            end
            rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
            repeat (5) @(posedge clk);
            fin[gi] = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(fin[0] && fin[1]) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        if (!(fin[0] && fin[1])) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: stimulus did not complete within 20000 cycles");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
